// File: rtl/bsc_pkg.sv
// bsc_pkg: shared channel state encoding and preamble constant for the backscatter modulator.
package bsc_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, SEND} ch_state_t;
  localparam int PRE_LEN = 4;
  localparam logic [PRE_LEN-1:0] PREAMBLE = 4'b1010;
endpackage

// File: rtl/bsc_channel.sv
// bsc_channel: one FSK/OOK backscatter channel (FSM, shifter, bit timer, subcarrier divider).
// Optional BSC_PREAMBLE_EN prepends the 4-bit preamble as a SYNC phase.
module bsc_channel
  import bsc_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8,
  parameter int BIT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  half0,
  input  logic [DIV_W-1:0]  half1,
  input  logic [BIT_W-1:0]  bit_len,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              sig,
  output logic              ctrl
);
`ifdef BSC_PREAMBLE_EN
  localparam int FW = DATA_W + PRE_LEN;
  localparam ch_state_t FIRST = SYNC;
`else
  localparam int FW = DATA_W;
  localparam ch_state_t FIRST = SEND;
`endif
  localparam int IW = $clog2(FW);
  ch_state_t state_q, state_d;
  logic [FW-1:0] sh;
  logic [DIV_W-1:0] h0_q, h1_q, half_cnt, h_act;
  logic [BIT_W-1:0] blen, bit_cnt;
  logic [IW-1:0] bit_idx;
  logic sig_q, bnd;
  assign h_act = sh[FW-1] ? h1_q : h0_q;
  assign bnd = ctrl && (bit_cnt == blen - BIT_W'(1));
  assign tx_ready = (state_q == IDLE);
  assign ctrl = !tx_ready;
  // A zero half-period silences the carrier immediately, even on a bit's first cycle
  assign sig = ctrl & sig_q & (h_act != '0);
  always_comb begin
    state_d = state_q;
    if (tx_ready && tx_valid) state_d = FIRST;
    else if (bnd && state_q == SEND && bit_idx == '0) state_d = IDLE;
`ifdef BSC_PREAMBLE_EN
    else if (bnd && state_q == SYNC && bit_idx == IW'(DATA_W)) state_d = SEND;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= '0;
      h0_q     <= '0;
      h1_q     <= '0;
      blen     <= '0;
      bit_cnt  <= '0;
      half_cnt <= '0;
      bit_idx  <= '0;
      sig_q    <= 1'b0;
    end else if (tx_ready) begin
      bit_cnt  <= '0;
      half_cnt <= '0;
      sig_q    <= 1'b0;
      bit_idx  <= IW'(FW - 1);
      if (tx_valid) begin
`ifdef BSC_PREAMBLE_EN
        sh <= {PREAMBLE, tx_data};
`else
        sh <= tx_data;
`endif
        h0_q <= half0;
        h1_q <= half1;
        blen <= (bit_len == '0) ? BIT_W'(1) : bit_len;
      end
    end else if (bnd) begin
      // Bit boundary: restart the divider but keep sig level (phase-continuous)
      bit_cnt  <= '0;
      half_cnt <= '0;
      bit_idx  <= bit_idx - IW'(1);
      sh       <= sh << 1;
    end else begin
      bit_cnt <= bit_cnt + BIT_W'(1);
      if (h_act == '0) begin
        half_cnt <= '0;
        sig_q    <= 1'b0;
      end else if (half_cnt == h_act - DIV_W'(1)) begin
        half_cnt <= '0;
        sig_q    <= ~sig_q;
      end else half_cnt <= half_cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/backscatter_mod_mc.sv
// backscatter_mod_mc: NCH independent backscatter modulator channels plus a shared PWM bias generator.
// Define BSC_PREAMBLE_EN to prepend the 4'b1010 preamble to every frame.
module backscatter_mod_mc
  import bsc_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8,
  parameter int BIT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*DIV_W-1:0]  cfg_half0,
  input  logic [NCH*DIV_W-1:0]  cfg_half1,
  input  logic [NCH*BIT_W-1:0]  cfg_bit_len,
  input  logic [NCH-1:0]        tx_valid,
  input  logic [NCH*DATA_W-1:0] tx_data,
  output logic [NCH-1:0]        tx_ready,
  output logic [NCH-1:0]        sig,
  output logic [NCH-1:0]        ctrl,
  input  logic [DIV_W-1:0]      pwm_period,
  input  logic [DIV_W-1:0]      pwm_duty,
  output logic                  pwm,
  output logic                  busy
);
  logic [DIV_W-1:0] pwm_cnt, per_q;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    bsc_channel #(.DIV_W(DIV_W), .DATA_W(DATA_W), .BIT_W(BIT_W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .half0   (cfg_half0[g*DIV_W +: DIV_W]),
      .half1   (cfg_half1[g*DIV_W +: DIV_W]),
      .bit_len (cfg_bit_len[g*BIT_W +: BIT_W]),
      .tx_valid(tx_valid[g]),
      .tx_data (tx_data[g*DATA_W +: DATA_W]),
      .tx_ready(tx_ready[g]),
      .sig     (sig[g]),
      .ctrl    (ctrl[g])
    );
  end
  assign busy = |ctrl;
  // Period is reloaded only on wrap so a mid-cycle change cannot truncate the current period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      per_q   <= '0;
      pwm     <= 1'b0;
    end else begin
      pwm <= (pwm_cnt < pwm_duty);
      if (pwm_cnt == per_q) begin
        pwm_cnt <= '0;
        per_q   <= pwm_period;
      end else pwm_cnt <= pwm_cnt + DIV_W'(1);
    end
  end
endmodule
